// File: rtl/imm_encoder_if.sv
// Request/response bundle for the instruction-word assembler.
// The master side issues encode requests and consumes words; the slave side is the encoder.
interface imm_encoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [6:0]       in_opcode;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic             out_range_err;
    logic             out_align_err;
    logic             out_fmt_err;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_range_err, out_align_err,
               out_fmt_err, enc_count, err_count
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_range_err, out_align_err,
               out_fmt_err, enc_count, err_count
    );
endinterface

// File: rtl/imm_encoder.sv
// RISC-V instruction-word assembler: checks the immediate against the format's
// reach and alignment, scatters it into the instruction fields, and queues the
// word in a 2-entry FIFO with saturating good/bad word counters.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    imm_encoder_if.slave bus
);
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
    localparam logic [2:0] FMT_U = 3'd5;

    typedef struct packed {
        logic        fmt_err;
        logic        align_err;
        logic        range_err;
        logic [31:0] inst;
    } entry_t;

    logic [31:0] w_imm;
    logic        w_fits12;
    logic        w_fits13;
    logic        w_fits21;
    logic [31:0] w_raw;
    logic        w_rng;
    logic        w_aln;
    logic        w_fe;
    entry_t      w_entry;
    entry_t      w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_out_valid;
    logic [1:0]  w_count_nxt;

    entry_t           r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_enc_count;
    logic [CNT_W-1:0] r_err_count;

    // A signed value fits an N-bit field when every bit above the field MSB copies the sign.
    assign w_imm    = bus.in_imm;
    assign w_fits12 = (&w_imm[31:11]) | ~(|w_imm[31:11]);
    assign w_fits13 = (&w_imm[31:12]) | ~(|w_imm[31:12]);
    assign w_fits21 = (&w_imm[31:20]) | ~(|w_imm[31:20]);

    // Field scatter and error detection for the presented request.
    always_comb begin
        w_raw = '0;
        w_rng = 1'b0;
        w_aln = 1'b0;
        w_fe  = 1'b0;
        case (bus.in_fmt)
            FMT_R: w_raw = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            bus.in_rd, bus.in_opcode};
            FMT_I: begin
                w_rng = ~w_fits12;
                w_raw = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            end
            FMT_S: begin
                w_rng = ~w_fits12;
                w_raw = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         w_imm[4:0], bus.in_opcode};
            end
            FMT_B: begin
                w_rng = ~w_fits13;
                w_aln = w_imm[0];
                w_raw = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         w_imm[4:1], w_imm[11], bus.in_opcode};
            end
            FMT_J: begin
                w_rng = ~w_fits21;
                w_aln = w_imm[0];
                w_raw = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                         bus.in_rd, bus.in_opcode};
            end
            FMT_U: begin
                w_aln = |w_imm[11:0];
                w_raw = {w_imm[31:12], bus.in_rd, bus.in_opcode};
            end
            default: w_fe = 1'b1;
        endcase
    end

    // A flagged word is emitted as all-zero so it can never be mistaken for a real instruction.
    assign w_entry.fmt_err   = w_fe;
    assign w_entry.align_err = w_aln;
    assign w_entry.range_err = w_rng;
    assign w_entry.inst      = (w_rng | w_aln | w_fe) ? 32'd0 : w_raw;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = bus.in_valid & r_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // FIFO storage, pointers and registered in_ready (no path from out_ready to in_ready).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < 2'd2);
        end
    end

    // Saturating statistics, bumped when a word leaves the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_count <= '0;
            r_err_count <= '0;
        end else if (w_pop) begin
            if (w_head.fmt_err | w_head.align_err | w_head.range_err) begin
                if (r_err_count != {CNT_W{1'b1}}) r_err_count <= r_err_count + CNT_W'(1);
            end else begin
                if (r_enc_count != {CNT_W{1'b1}}) r_enc_count <= r_enc_count + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_inst      = w_out_valid ? w_head.inst : 32'd0;
    assign bus.out_range_err = w_out_valid & w_head.range_err;
    assign bus.out_align_err = w_out_valid & w_head.align_err;
    assign bus.out_fmt_err   = w_out_valid & w_head.fmt_err;
    assign bus.enc_count     = r_enc_count;
    assign bus.err_count     = r_err_count;
endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: requests push reference results, a negedge
// monitor pops and compares whenever a word is delivered.
module tb_imm_encoder;
    localparam int CNT_W = 4;
    localparam int SAT   = 15;

    typedef struct {
        logic [31:0] inst;
        logic        rng;
        logic        aln;
        logic        fe;
        logic [2:0]  fmt;
        logic [31:0] imm;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    imm_encoder_if #(.CNT_W(CNT_W)) bus ();

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_enc = 0;
    int model_err = 0;
    int acc_edge = 0;
    int pops = 0;
    int last_pop_edge = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference encoder written from the format rules: integer reach, then field placement.
    function automatic exp_t ref_encode(input logic [2:0] fmt, input logic [6:0] op,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] imm);
        exp_t e;
        longint s;
        logic [31:0] raw;
        s = longint'($signed(imm));
        e.rng = 1'b0; e.aln = 1'b0; e.fe = 1'b0; e.fmt = fmt; e.imm = imm;
        raw = 32'd0;
        case (fmt)
            3'd0: raw = {f7, rs2, rs1, f3, rd, op};
            3'd1: begin
                e.rng = (s < -2048) || (s > 2047);
                raw = {imm[11:0], rs1, f3, rd, op};
            end
            3'd2: begin
                e.rng = (s < -2048) || (s > 2047);
                raw = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            end
            3'd3: begin
                e.rng = (s < -4096) || (s > 4095);
                e.aln = (s % 2) != 0;
                raw = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            end
            3'd4: begin
                e.rng = (s < -1048576) || (s > 1048575);
                e.aln = (s % 2) != 0;
                raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            3'd5: begin
                e.aln = (imm % 32'd4096) != 32'd0;
                raw = {imm[31:12], rd, op};
            end
            default: e.fe = 1'b1;
        endcase
        e.inst = (e.rng || e.aln || e.fe) ? 32'd0 : raw;
        return e;
    endfunction

    // Immediate generator: recovers the sign-extended immediate from an encoded word.
    function automatic logic [31:0] decode_imm(input logic [2:0] fmt, input logic [31:0] w);
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        logic [31:0] r;
        r = 32'd0;
        case (fmt)
            3'd1: begin i12 = w[31:20]; r = 32'($signed(i12)); end
            3'd2: begin i12 = {w[31:25], w[11:7]}; r = 32'($signed(i12)); end
            3'd3: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; r = 32'($signed(b13)); end
            3'd4: begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; r = 32'($signed(j21)); end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: counter tracking, stall stability, and scoreboard comparison on each delivery.
    initial begin : monitor
        exp_t e;
        logic hold;
        logic [34:0] prev;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                check("enc_count", 64'(bus.enc_count), 64'(model_enc));
                check("err_count", 64'(bus.err_count), 64'(model_err));
                if (hold) begin
                    check("stall_valid", 64'(bus.out_valid), 64'd1);
                    check("stall_stable",
                          64'({bus.out_fmt_err, bus.out_align_err, bus.out_range_err, bus.out_inst}),
                          64'(prev));
                end
                if (bus.out_valid) begin
                    if (bus.out_ready) begin
                        if (sb.size() == 0) begin
                            check("unexpected_word", 64'(bus.out_inst), 64'hDEAD_BEEF_0000_0000);
                        end else begin
                            e = sb.pop_front();
                            check("out_inst", 64'(bus.out_inst), 64'(e.inst));
                            check("flags", 64'({bus.out_fmt_err, bus.out_align_err, bus.out_range_err}),
                                  64'({e.fe, e.aln, e.rng}));
                            if (!(e.rng || e.aln || e.fe) && e.fmt >= 3'd1 && e.fmt <= 3'd4)
                                check("round_trip", 64'(decode_imm(e.fmt, bus.out_inst)), 64'(e.imm));
                            if (e.rng || e.aln || e.fe) begin
                                if (model_err < SAT) model_err++;
                            end else begin
                                if (model_enc < SAT) model_enc++;
                            end
                        end
                        pops++;
                        last_pop_edge = cyc + 1;
                        hold = 1'b0;
                    end else begin
                        hold = 1'b1;
                        prev = {bus.out_fmt_err, bus.out_align_err, bus.out_range_err, bus.out_inst};
                    end
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    // Issue one request and wait (bounded) for acceptance; returns at posedge+1 with in_valid low.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        bus.in_fmt = fmt; bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1;
        bus.in_rs2 = rs2; bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm;
        bus.in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) acc_edge = cyc + 1;
            @(posedge clk);
            n++;
        end
        if (acc) sb.push_back(ref_encode(fmt, op, rd, rs1, rs2, f3, f7, imm));
        else check("accept_timeout", 64'd0, 64'd1);
        #1 bus.in_valid = 1'b0;
    endtask

    // Directed request: hold the word, check it at the head against a fixed value, then release it.
    task automatic send_check(input string name, input logic [2:0] fmt, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [31:0] imm,
                              input logic [31:0] want, input logic [2:0] want_flags);
        bus.out_ready = 1'b0;
        send(fmt, op, rd, rs1, rs2, f3, 7'd0, imm);
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_inst"}, 64'(bus.out_inst), 64'(want));
        check({name, "_flags"}, 64'({bus.out_fmt_err, bus.out_align_err, bus.out_range_err}),
              64'(want_flags));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic send_rand(input bit legal);
        logic [2:0]  fmt;
        logic [31:0] imm;
        int v;
        if (legal) begin
            fmt = 3'($urandom_range(0, 5));
            case (fmt)
                3'd1, 3'd2: begin v = int'($urandom_range(0, 4095)) - 2048; imm = v; end
                3'd3: begin v = (int'($urandom_range(0, 4095)) - 2048) * 2; imm = v; end
                3'd4: begin v = (int'($urandom_range(0, 1048575)) - 524288) * 2; imm = v; end
                3'd5: imm = $urandom & 32'hFFFF_F000;
                default: imm = $urandom;
            endcase
        end else begin
            fmt = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: begin v = int'($urandom_range(0, 10000)) - 5000; imm = v; end
                2: begin v = int'($urandom_range(0, 4000000)) - 2000000; imm = v; end
                default: imm = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 1));
            endcase
        end
        send(fmt, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 7'($urandom), imm);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int first_acc;
        int pops0;
        int pop_edge;
        bit done;
        bus.in_valid = 1'b0; bus.in_fmt = 3'd0; bus.in_opcode = 7'd0; bus.in_rd = 5'd0;
        bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0; bus.in_funct3 = 3'd0; bus.in_funct7 = 7'd0;
        bus.in_imm = 32'd0; bus.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_inst", 64'(bus.out_inst), 64'd0);
        check("rst_flags", 64'({bus.out_fmt_err, bus.out_align_err, bus.out_range_err}), 64'd0);
        check("rst_counts", 64'({bus.enc_count, bus.err_count}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // I-type addi x5,x6,-1
        send_check("addi", 3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF3_0293, 3'b000);
        check("addi_enc_count", 64'(bus.enc_count), 64'd1);

        // B-type beq x1,x2 boundaries
        send_check("beq_min", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd4096, 32'h8020_8063, 3'b000);
        send_check("beq_rng", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd4098, 32'h0, 3'b001);
        send_check("beq_6", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd6, 32'h0020_8363, 3'b000);
        send_check("beq_odd", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd7, 32'h0, 3'b010);
        check("beq_err_count", 64'(bus.err_count), 64'd2);
        send_check("beq_both", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8193, 32'h0, 3'b011);

        // J / U
        send_check("jal_max", 3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1048574, 32'h7FFF_F0EF, 3'b000);
        send_check("jal_rng", 3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1048576, 32'h0, 3'b001);
        send_check("lui", 3'd5, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 32'h1234_51B7, 3'b000);
        send_check("lui_aln", 3'd5, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 32'h1234_5001, 32'h0, 3'b010);
        send_check("sw_rng", 3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd2048, 32'h0, 3'b001);

        // Backpressure: two fill the buffer, the third waits for the first pop
        bus.out_ready = 1'b0;
        send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd100);
        check("bp_ready_after_1", 64'(bus.in_ready), 64'd1);
        send(3'd2, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, -32'sd8);
        check("bp_ready_after_2", 64'(bus.in_ready), 64'd0);
        pop_edge = 0;
        fork
            send(3'd0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20, 32'd0);
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
                pop_edge = cyc + 1;
            end
        join
        check("bp_third_accept_edge", 64'(acc_edge), 64'(pop_edge + 1));
        drain();

        // Streaming legal words at full rate
        bus.out_ready = 1'b1;
        pops0 = pops;
        send_rand(1'b1);
        first_acc = acc_edge;
        for (int k = 1; k < 1000; k++) send_rand(1'b1);
        check("stream_accept_span", 64'(acc_edge - first_acc), 64'd999);
        drain();
        check("stream_pops", 64'(pops - pops0), 64'd1000);
        check("stream_last_pop", 64'(last_pop_edge), 64'(acc_edge + 1));
        check("enc_saturated", 64'(bus.enc_count), 64'(SAT));

        // Mixed legal/illegal words with random backpressure
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 200; k++) send_rand(1'b0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();
        check("err_saturated", 64'(bus.err_count), 64'(SAT));

        // Asynchronous reset with two entries buffered
        bus.out_ready = 1'b0;
        send(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd5);
        send(3'd1, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd6);
        #2 rst_n = 1'b0;
        sb.delete();
        model_enc = 0;
        model_err = 0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_counts", 64'({bus.enc_count, bus.err_count}), 64'd0);
        check("arst_out_inst", 64'(bus.out_inst), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        check("arst_no_replay", 64'(bus.out_valid), 64'd0);
        send_check("fmt7", 3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0, 32'h0, 3'b100);
        check("fmt7_err_count", 64'(bus.err_count), 64'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Streaming RISC-V instruction-word assembler; inverse of the immediate generator.
- Accepts format, opcode, register fields and a 32-bit signed immediate. Range- and alignment-checks the immediate, scatters its bits into the format's instruction fields, and emits the 32-bit word.
- Sits between the test-program generator / self-check logic and instruction memory. Valid/ready on both sides, 2-entry output buffer, running statistics counters.

Parameters:
- CNT_W, 16, width of the encoded-instruction and error counters (saturating).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=J, 5=U, 6/7 illegal.
- in_opcode  in  7  copied to inst[6:0].
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R only).
- in_imm  in  32  two's-complement immediate, byte offset for B/J.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts.
- out_inst  out  32  encoded instruction.
- out_range_err  out  1  immediate out of range for format.
- out_align_err  out  1  alignment violation.
- out_fmt_err  out  1  illegal format code.
- enc_count  out  CNT_W  words delivered without error.
- err_count  out  CNT_W  words delivered with any error flag.

Behaviour:
- Reset (async, rst_n=0):
  - Buffer emptied; out_valid=0, out_inst=0, all err flags 0, enc_count=0, err_count=0.
  - in_ready=1 from the first cycle after release.
  - Assertion mid-transfer discards buffered entries; nothing is replayed.
- Handshakes:
  - Input transfer when in_valid&in_ready. Output transfer when out_valid&out_ready.
  - out_* stable while out_valid=1 and out_ready=0.
- Buffer and latency:
  - 2-entry FIFO of {inst, 3 err bits}. in_ready = (occupancy<2), registered, with no combinational path from out_ready.
  - Latency 1: a word accepted at edge N shows out_valid=1 after edge N if the buffer was empty.
  - Throughput 1 word/cycle when out_ready=1.
  - Full buffer: in_ready=0 even if out_ready=1 that cycle; it rises the cycle after a pop.
  - Simultaneous push and pop keeps occupancy unchanged. Order strictly FIFO.
- Encoding (combinational before the buffer), i = in_imm:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; imm ignored.
  - I: range -2048..2047; {i[11:0], rs1, funct3, rd, opcode}.
  - S: range -2048..2047; {i[11:5], rs2, rs1, funct3, i[4:0], opcode}.
  - B: range -4096..4094, i[0]=0; {i[12], i[10:5], rs2, rs1, funct3, i[4:1], i[11], opcode}.
  - J: range -1048576..1048574, i[0]=0; {i[20], i[10:1], i[11], i[19:12], rd, opcode}.
  - U: i[11:0] must be 0, else align_err; {i[31:12], rd, opcode}; no range error.
  - fmt 6/7: fmt_err=1, range/align not evaluated.
  - Range check is signed over the full 32 bits: bits above the field MSB must equal the sign bit.
  - Any error flag set forces out_inst=0. Flags are independent; B/J can raise range and align together.
- Counters:
  - Update on the output transfer: enc_count+1 if no flag, else err_count+1.
  - Saturate at 2^CNT_W-1, no wrap.
- Round-trip invariant: for error-free I/S/B/J words, the immediate generator applied to out_inst returns in_imm exactly.

Test Plan:
- Reset then I-type addi x5,x6,-1 (opcode 0x13, funct3 0): out_inst=0xFFF30293 one cycle after acceptance, no flags, enc_count=1.
- B-type beq x1,x2,-4096 -> 0x80208063; same with imm=-4098 -> range_err=1, out_inst=0; imm=6 -> 0x00208363; imm=7 -> align_err=1. err_count=2 at end.
- J-type jal x1,+1048574 -> 0x7FFFF0EF; U-type lui x3 imm=0x12345000 -> 0x123451B7; U imm=0x12345001 -> align_err.
- Backpressure: out_ready=0, push 3 back-to-back -> in_ready drops after 2nd acceptance; release out_ready -> words emerge in order, third accepted the cycle after first pop, out_* held stable while stalled.
- Streaming: out_ready=1, 1000 random legal words -> one output per cycle, every word round-trips through the immediate generator. With CNT_W=4, enc_count saturates at 15.
- Assert rst_n mid-stream with 2 entries buffered -> out_valid=0 and counters=0 immediately (asynchronously); fmt=7 after release -> fmt_err=1, out_inst=0.
